// File: rtl/onehot_collector_if.sv
// Beat-in / result-out signal bundle for onehot_collector.
// The master drives beats and observes results; the slave is the collector.
interface onehot_collector_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic [WIDTH-1:0] data_i;
  logic             data_val_i;
  logic             data_last_i;
  logic [WIDTH-1:0] data_o;
  logic [CNT_W-1:0] cnt_o;
  logic             error_o;
  logic             data_val_o;

  modport master (
    output data_i, data_val_i, data_last_i,
    input  data_o, cnt_o, error_o, data_val_o
  );

  modport slave (
    input  data_i, data_val_i, data_last_i,
    output data_o, cnt_o, error_o, data_val_o
  );
endinterface

// File: rtl/onehot_collector.sv
// Reassembles a vector from a packet of one-hot beats.
// The result is OR of beats, a saturating beat count and an error flag.
module onehot_collector #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk_i,
  input logic               rst_i,
  onehot_collector_if.slave bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             close;

  logic [WIDTH-1:0] acc_eff, acc_sum;
  logic [CNT_W-1:0] cnt_eff, cnt_sum;
  logic             err_eff, err_sum;
  logic             is_onehot, beat_err;

  // The running totals count as empty in IDLE, so a new packet always starts clean.
  assign acc_eff = (state_q == COLLECT) ? acc_q : '0;
  assign cnt_eff = (state_q == COLLECT) ? cnt_q : '0;
  assign err_eff = (state_q == COLLECT) ? err_q : 1'b0;

  assign is_onehot = (bus.data_i != '0) &&
                     ((bus.data_i & (bus.data_i - WIDTH'(1))) == '0);
  assign beat_err  = !is_onehot || (|(bus.data_i & acc_eff));

  assign acc_sum = acc_eff | bus.data_i;
  assign cnt_sum = (cnt_eff == CNT_MAX) ? cnt_eff : cnt_eff + CNT_W'(1);
  assign err_sum = err_eff | beat_err;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    close   = 1'b0;
    if (bus.data_val_i) begin
      if (bus.data_last_i) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        close   = 1'b1;
      end else begin
        state_d = COLLECT;
        acc_d   = acc_sum;
        cnt_d   = cnt_sum;
        err_d   = err_sum;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Result registers change only when a packet closes and hold otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.data_o     <= '0;
      bus.cnt_o      <= '0;
      bus.error_o    <= 1'b0;
      bus.data_val_o <= 1'b0;
    end else begin
      bus.data_val_o <= close;
      if (close) begin
        bus.data_o  <= acc_sum;
        bus.cnt_o   <= cnt_sum;
        bus.error_o <= err_sum;
      end
    end
  end

endmodule

// File: tb/tb_onehot_collector.sv
// Self-checking bench for onehot_collector: beat table plus reset sequences,
// expected results queued on each driven last beat and popped on data_val_o.
module tb_onehot_collector;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] c;
    logic             e;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             v;
    logic             l;
    res_t             exp;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  onehot_collector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  onehot_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t held;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add(input logic [3:0] d, input logic v, input logic l,
                     input logic [3:0] ed, input logic [2:0] ec, input logic ee);
    vec_t x;
    x.d = d; x.v = v; x.l = l;
    x.exp.d = ed; x.exp.c = ec; x.exp.e = ee;
    vecs.push_back(x);
  endtask

  // Called just after a falling edge: drive one beat, let one rising edge pass, check.
  task automatic step(input vec_t x);
    res_t r;
    bus.data_i      = x.d;
    bus.data_val_i  = x.v;
    bus.data_last_i = x.l;
    if (x.v && x.l) sb.push_back(x.exp);
    @(posedge clk_i);
    #1;
    check("data_val_o", 32'(bus.data_val_o), 32'(x.v && x.l));
    if (bus.data_val_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: data_val_o with no expected result");
      end else begin
        r = sb.pop_front();
        check("data_o", 32'(bus.data_o), 32'(r.d));
        check("cnt_o", 32'(bus.cnt_o), 32'(r.c));
        check("error_o", 32'(bus.error_o), 32'(r.e));
        held = r;
      end
    end else begin
      check("data_o_hold", 32'(bus.data_o), 32'(held.d));
      check("cnt_o_hold", 32'(bus.cnt_o), 32'(held.c));
      check("error_o_hold", 32'(bus.error_o), 32'(held.e));
    end
    @(negedge clk_i);
  endtask

  task automatic check_zero(input string name);
    check({name, "_val"}, 32'(bus.data_val_o), 32'd0);
    check({name, "_data"}, 32'(bus.data_o), 32'd0);
    check({name, "_cnt"}, 32'(bus.cnt_o), 32'd0);
    check({name, "_err"}, 32'(bus.error_o), 32'd0);
  endtask

  initial begin
    vec_t x;
    // Two-beat packet with an idle gap
    add(4'b0001, 1, 0, 0, 0, 0);
    add(4'b1111, 0, 1, 0, 0, 0);
    add(4'b0100, 1, 1, 4'b0101, 3'd2, 0);
    // Full packet on consecutive cycles
    add(4'b0001, 1, 0, 0, 0, 0);
    add(4'b0010, 1, 0, 0, 0, 0);
    add(4'b0100, 1, 0, 0, 0, 0);
    add(4'b1000, 1, 1, 4'b1111, 3'd4, 0);
    add(4'b0000, 0, 0, 0, 0, 0);
    // Repeated bit
    add(4'b0010, 1, 0, 0, 0, 0);
    add(4'b0010, 1, 1, 4'b0010, 3'd2, 1);
    // Zero and multi-hot singles
    add(4'b0000, 1, 1, 4'b0000, 3'd1, 1);
    add(4'b0110, 1, 1, 4'b0110, 3'd1, 1);
    // Back-to-back singles
    add(4'b1000, 1, 1, 4'b1000, 3'd1, 0);
    add(4'b0001, 1, 1, 4'b0001, 3'd1, 0);
    // Zero beat inside a packet
    add(4'b0001, 1, 0, 0, 0, 0);
    add(4'b0000, 1, 0, 0, 0, 0);
    add(4'b0010, 1, 1, 4'b0011, 3'd3, 1);
    // Counter saturation: eight beats, count stops at 7
    for (int i = 0; i < 7; i++) add(4'b0001, 1, 0, 0, 0, 0);
    add(4'b0001, 1, 1, 4'b0001, 3'd7, 1);
    add(4'b0000, 0, 0, 0, 0, 0);

    held = '0;
    // Reset asserted with a valid last beat present
    bus.data_i      = 4'b1111;
    bus.data_val_i  = 1'b1;
    bus.data_last_i = 1'b1;
    #1;
    check_zero("reset_t0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      check_zero("reset_hold");
    end
    @(negedge clk_i);
    bus.data_val_i = 1'b0;
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset mid-packet: partial packet is dropped
    x.d = 4'b0001; x.v = 1; x.l = 0; x.exp = '0;
    step(x);
    x.d = 4'b0010;
    step(x);
    rst_i = 1'b1;
    #1;
    check_zero("reset_mid");
    @(posedge clk_i);
    #1;
    check_zero("reset_mid_edge");
    @(negedge clk_i);
    rst_i = 1'b0;
    held  = '0;
    x.d = 4'b1000; x.v = 1; x.l = 1;
    x.exp.d = 4'b1000; x.exp.c = 3'd1; x.exp.e = 1'b0;
    step(x);
    x.d = 4'b0000; x.v = 0; x.l = 0; x.exp = '0;
    step(x);
    step(x);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
